// File: rtl/uart_pkg.sv
// Shared UART definitions: data/FIFO sizing, status-bit positions and the
// push/pop operation encoding used by the receive buffer.
package uart_pkg;

   localparam int UART_DATA_W   = 8;
   localparam int UART_RX_DEPTH = 8;
   localparam int UART_RX_AW    = 3;

   localparam int RX_EMPTY = 0;
   localparam int RX_FULL  = 1;
   localparam int RX_OVR   = 2;

   typedef enum logic [1:0] {
      FIFO_IDLE = 2'b00,
      FIFO_PUSH = 2'b01,
      FIFO_POP  = 2'b10,
      FIFO_BOTH = 2'b11
   } fifo_op_e;

   function automatic fifo_op_e fifo_op(input logic push, input logic pop);
      return fifo_op_e'({pop, push});
   endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// DEPTH x DW register array for the UART receive FIFO: one synchronous
// write port, one asynchronous read port. Contents are never reset.
module uart_fifo_mem
   import uart_pkg::*;
#(
   parameter int DEPTH = UART_RX_DEPTH,
   parameter int AW    = UART_RX_AW,
   parameter int DW    = UART_DATA_W
) (
   input  logic          sysclk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];

   always_ff @(posedge sysclk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// UART receive byte buffer: captures rx_valid strobes into a small FIFO,
// presents the head byte and reports empty/full/count/sticky overrun.
// Define UART_RX_IRQ_EN to build the registered level/overrun interrupt;
// otherwise irq is tied low.
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DEPTH     = UART_RX_DEPTH,
   parameter int AW        = UART_RX_AW,
   parameter int IRQ_LEVEL = 1
) (
   input  logic                   sysclk,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [UART_DATA_W-1:0] rx_data,
   input  logic                   rd_en,
   output logic [UART_DATA_W-1:0] rd_data,
   output logic                   empty,
   output logic                   full,
   output logic [AW:0]            count,
   output logic                   overrun,
   input  logic                   ovr_clr,
   output logic                   irq
);

   localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

   if (DEPTH < 2 || (1 << AW) != DEPTH || IRQ_LEVEL < 1 || IRQ_LEVEL > DEPTH) begin : g_param_check
      $error("uart_rx_buffer: DEPTH must be 2**AW (>=2) and IRQ_LEVEL in 1..DEPTH");
   end

   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [AW:0]            count_q, count_d;
   logic                   empty_q, empty_d;
   logic                   full_q, full_d;
   logic                   overrun_q, overrun_d;
   logic                   push, pop, ovr_event;
   logic [UART_DATA_W-1:0] mem_rdata;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   always_comb begin
      push      = rx_valid && (!full_q || rd_en);
      pop       = rd_en && !empty_q;
      ovr_event = rx_valid && full_q && !rd_en;

      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

      count_d = count_q;
      case (fifo_op(push, pop))
         FIFO_PUSH: count_d = count_q + (AW+1)'(1);
         FIFO_POP:  count_d = count_q - (AW+1)'(1);
         default:   count_d = count_q;
      endcase

      empty_d   = (count_d == '0);
      full_d    = (count_d == DEPTH_CNT);
      overrun_d = ovr_clr ? 1'b0 : (overrun_q | ovr_event);
   end

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         empty_q   <= 1'b1;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         empty_q   <= empty_d;
         full_q    <= full_d;
         overrun_q <= overrun_d;
      end
   end

   uart_fifo_mem #(
      .DEPTH (DEPTH),
      .AW    (AW),
      .DW    (UART_DATA_W)
   ) u_mem (
      .sysclk (sysclk),
      .we     (push),
      .waddr  (wr_ptr_q),
      .wdata  (rx_data),
      .raddr  (rd_ptr_q),
      .rdata  (mem_rdata)
   );

   // Gating on empty keeps rd_data at zero after reset without clearing the array.
   assign rd_data = empty_q ? '0 : mem_rdata;
   assign empty   = empty_q;
   assign full    = full_q;
   assign count   = count_q;
   assign overrun = overrun_q;

`ifdef UART_RX_IRQ_EN
   localparam logic [AW:0] IRQ_CNT = (AW+1)'(IRQ_LEVEL);

   logic irq_q, irq_d;

   assign irq_d = (count_d >= IRQ_CNT) | overrun_d;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: table of per-cycle vectors with
// hand-derived count/overrun expectations plus a byte scoreboard queue.
module tb_uart_rx_buffer;

   localparam int TB_DEPTH     = 8;
   localparam int TB_IRQ_LEVEL = 4;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data  = 8'h00;
   logic       rd_en    = 1'b0;
   logic       ovr_clr  = 1'b0;
   logic [7:0] rd_data;
   logic       empty, full, overrun, irq;
   logic [3:0] count;

   uart_rx_buffer #(
      .DEPTH     (TB_DEPTH),
      .AW        (3),
      .IRQ_LEVEL (TB_IRQ_LEVEL)
   ) dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .rx_valid (rx_valid),
      .rx_data  (rx_data),
      .rd_en    (rd_en),
      .rd_data  (rd_data),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overrun  (overrun),
      .ovr_clr  (ovr_clr),
      .irq      (irq)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       r;
      logic       c;
      int         cnt;
      logic       ovr;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] sb[$];
   int         prev_cnt = 0;
   int         n_vec = 0;
   int         n_cmp = 0;
   int         n_err = 0;

   function automatic vec_t mk(logic v, logic [7:0] d, logic r, logic c, int cnt, logic ovr);
      vec_t x;
      x.v = v; x.d = d; x.r = r; x.c = c; x.cnt = cnt; x.ovr = ovr;
      return x;
   endfunction

   function automatic logic exp_irq(int cnt, logic ovr);
`ifdef UART_RX_IRQ_EN
      return (cnt >= TB_IRQ_LEVEL) || ovr;
`else
      return 1'b0;
`endif
   endfunction

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at step %0d: got %0h expected %0h", name, idx, act, exp);
      end
   endtask

   task automatic check_state(input int idx, input int cnt, input logic ovr);
      chk("count",   idx, 32'(count),   32'(cnt));
      chk("empty",   idx, 32'(empty),   32'(cnt == 0));
      chk("full",    idx, 32'(full),    32'(cnt == TB_DEPTH));
      chk("overrun", idx, 32'(overrun), 32'(ovr));
      chk("irq",     idx, 32'(irq),     32'(exp_irq(cnt, ovr)));
      if (cnt != 0) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard at step %0d: queue empty but count %0d", idx, cnt);
         end else begin
            chk("rd_data", idx, 32'(rd_data), 32'(sb[0]));
         end
      end
   endtask

   // Drive one vector at negedge, update the scoreboard, check after the posedge.
   task automatic apply(input vec_t x, input int idx);
      @(negedge sysclk);
      rx_valid = x.v;
      rx_data  = x.d;
      rd_en    = x.r;
      ovr_clr  = x.c;
      if (x.r && prev_cnt != 0 && sb.size() != 0) void'(sb.pop_front());
      if (x.v && (prev_cnt < TB_DEPTH || x.r)) sb.push_back(x.d);
      @(posedge sysclk);
      #1;
      check_state(idx, x.cnt, x.ovr);
      prev_cnt = x.cnt;
      n_vec++;
   endtask

   initial begin
      // Reset held with rx_valid pulses: nothing may be written.
      for (int i = 0; i < 4; i++) begin
         @(negedge sysclk);
         rx_valid = ~rx_valid;
         rx_data  = 8'h5A;
         @(posedge sysclk);
         #1;
         check_state(-1, 0, 1'b0);
         n_vec++;
      end
      @(negedge sysclk);
      rx_valid = 1'b0;
      reset    = 1'b1;
      #1;
      chk("rd_data_after_reset", -1, 32'(rd_data), 32'h00);
      chk("empty_after_reset",   -1, 32'(empty),   32'h1);

      // Two pushes then pops, plus a read while empty.
      vecs.push_back(mk(1, 8'hA5, 0, 0, 1, 0));
      vecs.push_back(mk(1, 8'h3C, 0, 0, 2, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0));
      // Nine pushes: 09 dropped, overrun set; clear beats a same-cycle overrun.
      for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 8'(i), 0, 0, i, 0));
      vecs.push_back(mk(1, 8'h09, 0, 0, 8, 1));
      vecs.push_back(mk(1, 8'hAA, 0, 1, 8, 0));
      for (int i = 7; i >= 0; i--) vecs.push_back(mk(0, 8'h00, 1, 0, i, 0));
      // Full with push and pop together: count stays 8, EE read last.
      for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'hE0 + 8'(i), 0, 0, i + 1, 0));
      vecs.push_back(mk(1, 8'hEE, 1, 0, 8, 0));
      for (int i = 7; i >= 0; i--) vecs.push_back(mk(0, 8'h00, 1, 0, i, 0));
      // Empty with push and pop together: push only.
      vecs.push_back(mk(1, 8'h55, 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0));
      // Overrun stays sticky through a full drain until cleared.
      for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 8'hC0 + 8'(i), 0, 0, i + 1, 0));
      vecs.push_back(mk(1, 8'h77, 0, 0, 8, 1));
      for (int i = 7; i >= 0; i--) vecs.push_back(mk(0, 8'h00, 1, 0, i, 1));
      vecs.push_back(mk(0, 8'h00, 0, 1, 0, 0));
      // Wrap: 20 push/pop pairs.
      for (int i = 0; i < 20; i++) begin
         vecs.push_back(mk(1, 8'h10 + 8'(i), 0, 0, 1, 0));
         vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0));
      end
      // Streaming at count 1 with simultaneous push/pop.
      vecs.push_back(mk(1, 8'hF0, 0, 0, 1, 0));
      for (int i = 1; i <= 5; i++) vecs.push_back(mk(1, 8'hF0 + 8'(i), 1, 0, 1, 0));
      vecs.push_back(mk(0, 8'h00, 1, 0, 0, 0));

      for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

      // Asynchronous reset mid-cycle from a full, overrun state.
      for (int i = 0; i < 8; i++) apply(mk(1, 8'h80 + 8'(i), 0, 0, i + 1, 0), 1000 + i);
      apply(mk(1, 8'h99, 0, 0, 8, 1), 1008);
      @(negedge sysclk);
      rx_valid = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      chk("async_count",   2000, 32'(count),   32'h0);
      chk("async_empty",   2000, 32'(empty),   32'h1);
      chk("async_full",    2000, 32'(full),    32'h0);
      chk("async_overrun", 2000, 32'(overrun), 32'h0);
      chk("async_irq",     2000, 32'(irq),     32'h0);
      chk("async_rd_data", 2000, 32'(rd_data), 32'h00);
      sb.delete();
      prev_cnt = 0;
      @(negedge sysclk);
      reset = 1'b1;
      apply(mk(1, 8'hAB, 0, 0, 1, 0), 2001);
      apply(mk(1, 8'hCD, 0, 0, 2, 0), 2002);
      apply(mk(0, 8'h00, 1, 0, 1, 0), 2003);
      apply(mk(0, 8'h00, 1, 0, 0, 0), 2004);

      @(negedge sysclk);
      rx_valid = 1'b0;
      rd_en    = 1'b0;
      ovr_clr  = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
